ux607_qspi_flash_seq: RTL and testbench
=======================================

// Module: ux607_qspi_flash_seq
// PURPOSE
//  Read sequencer that drives one inner port of the QSPI link arbiter.
//  Each read request becomes one chip-select transaction: command, address, pad, then BEATS data frames.
//  Data bytes are returned as one response word.
//  link_lock is held for the whole transaction, so the arbiter cannot switch owners mid-frame.
// PARAMETERS
//  ADDR_BYTES   3   address bytes sent MSB-first (3 or 4); unused upper req_addr bits ignored
//  BEATS        4   data bytes per read (1..8)
//  TIMEOUT_CYC  256 watchdog limit; used only with QSPI_FLASH_SEQ_TIMEOUT_EN
// PORTS
//  clock           in  1        sole clock
//  reset           in  1        synchronous, active-high
//  req_valid       in  1        read request
//  req_ready       out 1        high only in IDLE
//  req_addr        in  32       flash byte address
//  resp_valid      out 1        response available
//  resp_ready      in  1        response accepted
//  resp_data       out 8*BEATS  byte k at bits [8k+7:8k], k = receive order
//  resp_err        out 1        timeout abort (0 when macro absent)
//  cfg_cmd_en      in  1        send command phase
//  cfg_cmd_code    in  8        command opcode
//  cfg_cmd_proto   in  2        proto for command frame
//  cfg_addr_proto  in  2        proto for address frames
//  cfg_pad_cnt     in  4        pad frame length; 0 = no pad frame
//  cfg_data_proto  in  2        proto for pad and data frames
//  link_tx_ready   in  1        link accepts frame
//  link_tx_valid   out 1        frame request
//  link_tx_bits    out 8        frame tx byte
//  link_rx_valid   in  1        rx byte strobe
//  link_rx_bits    in  8        rx byte
//  link_cnt        out 8        frame length
//  link_fmt_proto  out 2        frame proto
//  link_fmt_endian out 1        frame endian; tied 0 (MSB first)
//  link_fmt_iodir  out 1        1 = tx frame, 0 = rx frame
//  link_cs_set     out 1        CS control
//  link_cs_clear   out 1        CS control
//  link_cs_hold    out 1        CS control
//  link_active     in  1        link busy; CS_OFF waits for 0
//  link_lock       out 1        ownership lock to arbiter
// BEHAVIOUR
//  Reset and mid-operation reset:
//   - Any cycle with reset=1 returns the FSM to IDLE at the next edge.
//   - All outputs are 0 except req_ready=1; counters and resp_data are cleared.
//  States: IDLE > CMD > ADDR > PAD > DATA > WAIT_RX > CS_OFF > RESP > IDLE
//  IDLE:
//   - Accept on req_valid & req_ready.
//   - Capture req_addr and all cfg_* at acceptance; cfg is ignored thereafter.
//   - Next state is CMD if cfg_cmd_en, else ADDR.
//  Frame handshake:
//   - Frame issued when link_tx_valid & link_tx_ready; tx_valid stays high until then.
//   - Frame fields stay stable while tx_valid is high.
//  CMD: one frame, bits=cmd_code, cnt=8, proto=cmd_proto, iodir=1.
//  ADDR:
//   - ADDR_BYTES frames, MSB-first, cnt=8, proto=addr_proto, iodir=1.
//   - A byte counter advances per handshake.
//  PAD:
//   - Skipped when pad_cnt=0.
//   - Otherwise one frame: bits=0, cnt={4'b0,pad_cnt}, proto=data_proto, iodir=0.
//  DATA / WAIT_RX:
//   - Per beat, one frame: bits=0, cnt=8, proto=data_proto, iodir=0.
//   - WAIT_RX then waits for link_rx_valid and stores link_rx_bits into byte[beat].
//   - After BEATS bytes, go to CS_OFF.
//  rx outside WAIT_RX (CMD/ADDR/PAD echoes) is discarded.
//   - Same-cycle tx handshake and rx strobe: the rx is discarded, since the FSM is not yet in WAIT_RX.
//  CS control:
//   - cs_set=cs_hold=1 from leaving IDLE through WAIT_RX.
//   - CS_OFF: cs_hold=0, cs_clear=1 until link_active=0 is seen, then cs_clear=0 and go to RESP.
//  link_lock: 1 from the acceptance edge until CS_OFF exits; registered, no combinational paths.
//  RESP:
//   - resp_valid=1 and resp_data stable until resp_ready, then IDLE.
//   - Back-to-back requests: a new request is accepted the cycle after the handshake; no bubble.
//  Latency, zero-wait link, cmd_en=1, pad>0: 1+1+ADDR_BYTES+1+2*BEATS+1 cycles from accept to resp_valid.
// CONFIGURATION
//  QSPI_FLASH_SEQ_TIMEOUT_EN defined:
//   - The watchdog counts cycles in CMD..CS_OFF with no tx handshake and no rx strobe.
//   - At TIMEOUT_CYC: go to CS_OFF, set resp_err=1, resp_data=0.
//   - The CS_OFF clear is still performed before RESP.
//  Undefined: no counter; resp_err tied 0; the FSM waits indefinitely.
// TESTING
//  T1: cmd_en=1, code=0x03, addr=0x123456, pad=0, BEATS=4, rx 11,22,33,44
//      -> tx 03,12,34,56; resp_data=0x44332211.
//  T2: cmd_en=0, pad=8, proto=2 (quad) -> first frame addr 0x12; pad frame cnt=8, iodir=0; the pad rx byte is absent from resp.
//  T3: link_tx_ready held 0 for 10 cycles during ADDR -> tx_valid/bits stable; lock stays 1; completes normally.
//  T4: reset pulsed during DATA beat 2 -> next cycle IDLE, lock=0, cs_hold=0, req_ready=1.
//  T5: resp_ready low 5 cycles, next req_valid already high -> data held; new request accepted the cycle after the handshake.
//  T6 (macro on, TIMEOUT_CYC=16): rx never arrives -> cs_clear pulse, then resp_err=1, resp_data=0.

Source files
------------

// File: rtl/ux607_qspi_flash_seq_if.sv
// ux607_qspi_flash_seq_if: request/response/config bundle between a read requester and the flash sequencer.
//   master: req_valid, req_addr, resp_ready, cfg_* out; req_ready, resp_valid, resp_data, resp_err in
//   slave : the reverse (the sequencer side)
interface ux607_qspi_flash_seq_if #(
    parameter int BEATS = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_addr;
    logic               resp_valid;
    logic               resp_ready;
    logic [8*BEATS-1:0] resp_data;
    logic               resp_err;
    logic               cfg_cmd_en;
    logic [7:0]         cfg_cmd_code;
    logic [1:0]         cfg_cmd_proto;
    logic [1:0]         cfg_addr_proto;
    logic [3:0]         cfg_pad_cnt;
    logic [1:0]         cfg_data_proto;

    modport master (
        output req_valid, req_addr, resp_ready,
        output cfg_cmd_en, cfg_cmd_code, cfg_cmd_proto, cfg_addr_proto, cfg_pad_cnt, cfg_data_proto,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        input  cfg_cmd_en, cfg_cmd_code, cfg_cmd_proto, cfg_addr_proto, cfg_pad_cnt, cfg_data_proto,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/ux607_qspi_flash_seq.sv
// ux607_qspi_flash_seq: turns each read request into one chip-select QSPI transaction
//   (command, address, pad, BEATS data frames) and returns the bytes as one response word.
//   clock, reset          : clock, synchronous active-high reset
//   bus (slave)           : request/response handshake and per-request config
//   link_tx_*/link_fmt_*  : frame request towards the link arbiter port
//   link_rx_*             : received byte strobe
//   link_cs_*, link_active: chip-select control and link busy
//   link_lock             : keeps the arbiter on this port for the whole transaction
//   Optional watchdog: define QSPI_FLASH_SEQ_TIMEOUT_EN.
module ux607_qspi_flash_seq #(
    parameter int ADDR_BYTES  = 3,
    parameter int BEATS       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    ux607_qspi_flash_seq_if.slave bus,
    input  logic                  link_tx_ready,
    output logic                  link_tx_valid,
    output logic [7:0]            link_tx_bits,
    input  logic                  link_rx_valid,
    input  logic [7:0]            link_rx_bits,
    output logic [7:0]            link_cnt,
    output logic [1:0]            link_fmt_proto,
    output logic                  link_fmt_endian,
    output logic                  link_fmt_iodir,
    output logic                  link_cs_set,
    output logic                  link_cs_clear,
    output logic                  link_cs_hold,
    input  logic                  link_active,
    output logic                  link_lock
);
    if (ADDR_BYTES < 3 || ADDR_BYTES > 4 || BEATS < 1 || BEATS > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("ux607_qspi_flash_seq: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, CMD, ADDR, PAD, DATA, WAIT_RX, CS_OFF, RESP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [7:0]         code_q, code_d;
    logic [1:0]         cproto_q, cproto_d;
    logic [1:0]         aproto_q, aproto_d;
    logic [1:0]         dproto_q, dproto_d;
    logic [3:0]         pad_q, pad_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [8*BEATS-1:0] data_q, data_d;
    logic               lock_q, lock_d;
    logic               err_q, err_d;
    logic               accept, hs, last_addr, last_beat, timeout;

    assign accept    = bus.req_valid & bus.req_ready;
    assign hs        = link_tx_valid & link_tx_ready;
    assign last_addr = cnt_q == 3'(ADDR_BYTES - 1);
    assign last_beat = cnt_q == 3'(BEATS - 1);

`ifdef QSPI_FLASH_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            busy;
    // Any link activity (tx handshake or rx strobe) proves progress and restarts the count.
    assign busy    = state_q != IDLE && state_q != RESP;
    assign timeout = busy & ~hs & ~link_rx_valid & (wdog_q == WD_W'(TIMEOUT_CYC - 1));
    always_comb wdog_d = (!busy || hs || link_rx_valid || timeout) ? '0 : wdog_q + 1'b1;
    always_ff @(posedge clock) wdog_q <= reset ? '0 : wdog_d;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            code_q   <= '0;
            cproto_q <= '0;
            aproto_q <= '0;
            dproto_q <= '0;
            pad_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            code_q   <= code_d;
            cproto_q <= cproto_d;
            aproto_q <= aproto_d;
            dproto_q <= dproto_d;
            pad_q    <= pad_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = bus.cfg_cmd_en ? CMD : ADDR;
            CMD:     if (hs) state_d = ADDR;
            ADDR:    if (hs && last_addr) state_d = (pad_q != 4'd0) ? PAD : DATA;
            PAD:     if (hs) state_d = DATA;
            DATA:    if (hs) state_d = WAIT_RX;
            WAIT_RX: if (link_rx_valid) state_d = last_beat ? CS_OFF : DATA;
            CS_OFF:  if (!link_active) state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // An abort still routes through CS_OFF so chip-select is released before responding.
        if (timeout && state_d != RESP) state_d = CS_OFF;
    end

    always_comb begin
        addr_d   = addr_q;
        code_d   = code_q;
        cproto_d = cproto_q;
        aproto_d = aproto_q;
        dproto_d = dproto_q;
        pad_d    = pad_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        err_d    = err_q;
        if (accept) begin
            // Left-align the address so the next byte to send is always addr_q[31:24].
            addr_d   = bus.req_addr << (8 * (4 - ADDR_BYTES));
            code_d   = bus.cfg_cmd_code;
            cproto_d = bus.cfg_cmd_proto;
            aproto_d = bus.cfg_addr_proto;
            dproto_d = bus.cfg_data_proto;
            pad_d    = bus.cfg_pad_cnt;
            cnt_d    = '0;
            data_d   = '0;
            err_d    = 1'b0;
        end
        if (state_q == ADDR && hs) begin
            addr_d = addr_q << 8;
            cnt_d  = last_addr ? '0 : cnt_q + 1'b1;
        end
        if (state_q == WAIT_RX && link_rx_valid) begin
            data_d[8*cnt_q +: 8] = link_rx_bits;
            cnt_d                = cnt_q + 1'b1;
        end
        if (timeout) begin
            err_d  = 1'b1;
            data_d = '0;
        end
        lock_d = accept | (lock_q & ~(state_q == CS_OFF & ~link_active));
    end

    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_data  = data_q;
    assign bus.resp_err   = err_q;

    always_comb begin
        link_tx_valid   = state_q inside {CMD, ADDR, PAD, DATA};
        link_tx_bits    = state_q == CMD ? code_q : state_q == ADDR ? addr_q[31:24] : 8'h00;
        link_cnt        = state_q == PAD ? {4'h0, pad_q} : link_tx_valid ? 8'd8 : 8'd0;
        link_fmt_proto  = state_q == CMD ? cproto_q : state_q == ADDR ? aproto_q :
                          state_q inside {PAD, DATA} ? dproto_q : 2'd0;
        link_fmt_endian = 1'b0;
        link_fmt_iodir  = state_q inside {CMD, ADDR};
        link_cs_set     = state_q inside {CMD, ADDR, PAD, DATA, WAIT_RX};
        link_cs_hold    = link_cs_set;
        link_cs_clear   = state_q == CS_OFF;
        link_lock       = lock_q;
    end
endmodule

// File: tb/tb_ux607_qspi_flash_seq.sv
// tb_ux607_qspi_flash_seq: random and directed reads against a frame-list/byte-queue model of the flash link.
module tb_ux607_qspi_flash_seq;
    localparam int AB = 3;
    localparam int NB = 4;
`ifdef QSPI_FLASH_SEQ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 256;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_ready = 1'b0, tx_valid;
    logic [7:0] tx_bits;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_bits = 8'h00;
    logic [7:0] cnt;
    logic [1:0] proto;
    logic       endian, iodir, cs_set, cs_clear, cs_hold, lock;
    logic       active = 1'b0;

    always #5 clk = ~clk;

    ux607_qspi_flash_seq_if #(.BEATS(NB)) bus ();

    ux607_qspi_flash_seq #(.ADDR_BYTES(AB), .BEATS(NB), .TIMEOUT_CYC(TO)) dut (
        .clock(clk), .reset(rst), .bus(bus),
        .link_tx_ready(tx_ready), .link_tx_valid(tx_valid), .link_tx_bits(tx_bits),
        .link_rx_valid(rx_valid), .link_rx_bits(rx_bits), .link_cnt(cnt),
        .link_fmt_proto(proto), .link_fmt_endian(endian), .link_fmt_iodir(iodir),
        .link_cs_set(cs_set), .link_cs_clear(cs_clear), .link_cs_hold(cs_hold),
        .link_active(active), .link_lock(lock)
    );

    typedef struct {
        logic [7:0] bits;
        logic [7:0] cnt;
        logic [1:0] proto;
        logic       iodir;
        int         kind;
    } frame_t;

    frame_t     frames[$];
    logic [7:0] rx_got[$];
    logic [7:0] rx_fixed[$];
    int         n_tests = 0, n_fail = 0;
    bit         zero_wait = 0, junk_en = 1, no_rx = 0, stall_req = 0, saw_clear = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frames(input bit ce, input logic [7:0] code, input logic [1:0] cp, input logic [1:0] ap,
                               input logic [1:0] dp, input logic [3:0] pad, input logic [31:0] addr);
        if (ce) frames.push_back('{code, 8'd8, cp, 1'b1, 0});
        for (int i = AB - 1; i >= 0; i--) frames.push_back('{addr[8*i +: 8], 8'd8, ap, 1'b1, 1});
        if (pad != 4'd0) frames.push_back('{8'h00, {4'h0, pad}, dp, 1'b0, 2});
        for (int i = 0; i < NB; i++) frames.push_back('{8'h00, 8'd8, dp, 1'b0, 3});
    endtask

    task automatic scramble();
        bus.cfg_cmd_en     = 1'($urandom);
        bus.cfg_cmd_code   = 8'($urandom);
        bus.cfg_cmd_proto  = 2'($urandom);
        bus.cfg_addr_proto = 2'($urandom);
        bus.cfg_pad_cnt    = 4'($urandom);
        bus.cfg_data_proto = 2'($urandom);
        bus.req_addr       = $urandom;
    endtask

    task automatic drive_req(input bit ce, input logic [7:0] code, input logic [1:0] cp, input logic [1:0] ap,
                             input logic [1:0] dp, input logic [3:0] pad, input logic [31:0] addr);
        bus.cfg_cmd_en     = ce;
        bus.cfg_cmd_code   = code;
        bus.cfg_cmd_proto  = cp;
        bus.cfg_addr_proto = ap;
        bus.cfg_data_proto = dp;
        bus.cfg_pad_cnt    = pad;
        bus.req_addr       = addr;
        bus.req_valid      = 1'b1;
        push_frames(ce, code, cp, ap, dp, pad, addr);
    endtask

    task automatic rand_req();
        logic [3:0] pad;
        pad = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        drive_req(1'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), pad, $urandom);
    endtask

    // Returns at the negedge after the accept edge, with cfg already scrambled.
    task automatic wait_accept();
        int n = 0;
        while (!bus.req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("accept_timeout", 64'(0), 64'(1));
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        saw_clear = 0;
        while (!bus.resp_valid && n < 2000) begin
            @(negedge clk);
            n++;
            if (cs_clear) saw_clear = 1;
        end
        if (!bus.resp_valid) check("resp_timeout", 64'(0), 64'(1));
    endtask

    task automatic check_data(input bit exp_err);
        logic [63:0] exp = '0;
        if (!exp_err) begin
            check("rx_count", 64'(rx_got.size()), 64'(NB));
            check("frames_left", 64'(frames.size()), 64'(0));
            for (int k = 0; k < NB && k < rx_got.size(); k++) exp[8*k +: 8] = rx_got[k];
        end
        check("resp_data", 64'(bus.resp_data), exp);
        check("resp_err", 64'(bus.resp_err), 64'(exp_err));
        check("cs_clear_seen", 64'(saw_clear), 64'(1));
        check("lock_in_resp", 64'(lock), 64'(0));
    endtask

    task automatic release_resp(input int stall);
        logic [63:0] held;
        held = 64'(bus.resp_data);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("resp_hold_valid", 64'(bus.resp_valid), 64'(1));
            check("resp_hold_data", 64'(bus.resp_data), held);
            check("resp_hold_busy", 64'(bus.req_ready), 64'(0));
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("idle_after_resp", 64'({bus.req_ready, bus.resp_valid}), 64'(2'b10));
        rx_got.delete();
    endtask

    // Link model: random ready, checks each issued frame against the expected list, returns one byte per data frame.
    initial begin
        bit          pend = 0, prev_wait = 0, hs;
        int          dly = 0, stall_n = 0;
        logic [7:0]  pbyte;
        logic [19:0] prev_f;
        frame_t      f;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
                prev_wait = 0;
                stall_n = 0;
                tx_ready = 1'b0;
                rx_valid = 1'b0;
                active = 1'b0;
            end else begin
                if (prev_wait) begin
                    check("tx_hold_valid", 64'(tx_valid), 64'(1));
                    check("tx_hold_fields", 64'({tx_bits, cnt, proto, iodir, endian}), 64'(prev_f));
                end
                if (tx_valid) begin
                    check("lock_in_frame", 64'(lock), 64'(1));
                    check("cs_in_frame", 64'({cs_set, cs_hold, cs_clear}), 64'(3'b110));
                end
                rx_valid = 1'b0;
                rx_bits  = 8'($urandom);
                if (pend) begin
                    if (dly == 0) begin
                        rx_valid = 1'b1;
                        rx_bits  = pbyte;
                        rx_got.push_back(pbyte);
                        pend = 0;
                    end else dly--;
                end else if (junk_en && $urandom_range(0, 5) == 0) rx_valid = 1'b1;
                if (stall_req && tx_valid && frames.size() > 0 && frames[0].kind == 1) begin
                    stall_n = 10;
                    stall_req = 0;
                end
                if (stall_n > 0) begin
                    tx_ready = 1'b0;
                    stall_n--;
                end else tx_ready = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
                hs        = tx_valid && tx_ready;
                prev_wait = tx_valid && !tx_ready;
                prev_f    = {tx_bits, cnt, proto, iodir, endian};
                if (hs) begin
                    if (frames.size() == 0) check("tx_unexpected", 64'(1), 64'(0));
                    else begin
                        f = frames.pop_front();
                        check("tx_frame", 64'({tx_bits, cnt, proto, iodir, endian}),
                              64'({f.bits, f.cnt, f.proto, f.iodir, 1'b0}));
                        if (f.kind == 3 && !no_rx) begin
                            pend  = 1;
                            dly   = zero_wait ? 0 : int'($urandom_range(0, 2));
                            pbyte = rx_fixed.size() > 0 ? rx_fixed.pop_front() : 8'($urandom);
                        end
                    end
                end
                active = zero_wait ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int lat;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        scramble();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("rst_outputs", 64'({bus.resp_valid, bus.resp_err, tx_valid, tx_bits, cnt, proto, endian, iodir,
                                  cs_set, cs_clear, cs_hold, lock}), 64'(0));
        check("rst_resp_data", 64'(bus.resp_data), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // T1: fixed bytes, zero-wait link, no pad
        zero_wait = 1;
        rx_fixed = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_req(1'b1, 8'h03, 2'd0, 2'd0, 2'd0, 4'd0, 32'h0012_3456);
        wait_accept();
        wait_resp(lat);
        check("t1_latency", 64'(lat), 64'(1 + 1 + AB + 2 * NB + 1));
        check("t1_word", 64'(bus.resp_data), 64'h4433_2211);
        check_data(0);
        release_resp(0);

        // Latency with a pad frame
        drive_req(1'b1, 8'h0B, 2'd1, 2'd1, 2'd2, 4'd5, $urandom);
        wait_accept();
        wait_resp(lat);
        check("pad_latency", 64'(lat), 64'(1 + 1 + AB + 1 + 2 * NB + 1));
        check_data(0);
        release_resp(1);
        zero_wait = 0;

        // T2: no command, quad pad of 8 cycles
        drive_req(1'b0, 8'hEB, 2'd0, 2'd2, 2'd2, 4'd8, 32'h0012_3456);
        wait_accept();
        wait_resp(lat);
        check_data(0);
        release_resp(2);

        // T3: 10-cycle stall inside the address phase
        stall_req = 1;
        drive_req(1'b1, 8'h0B, 2'd0, 2'd0, 2'd0, 4'd0, $urandom);
        wait_accept();
        wait_resp(lat);
        check("t3_stall_done", 64'(stall_req), 64'(0));
        check_data(0);
        release_resp(0);

        // T4: reset in the middle of the data phase
        rand_req();
        wait_accept();
        for (int n = 0; rx_got.size() < 2 && n < 500; n++) @(negedge clk);
        check("t4_reached_beat2", 64'(rx_got.size() >= 2), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("t4_idle", 64'({bus.req_ready, lock, cs_hold, cs_set, tx_valid, bus.resp_valid}), 64'(6'b100000));
        frames.delete();
        rx_got.delete();
        rx_fixed.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // T5: held response with the next request already waiting
        rand_req();
        wait_accept();
        wait_resp(lat);
        check_data(0);
        rand_req();
        release_resp(5);
        @(negedge clk);
        check("t5_accepted", 64'({bus.req_ready, lock}), 64'(2'b01));
        bus.req_valid = 1'b0;
        scramble();
        wait_resp(lat);
        check_data(0);
        release_resp(0);

`ifdef QSPI_FLASH_SEQ_TIMEOUT_EN
        // T6: data never returns
        zero_wait = 1;
        no_rx = 1;
        junk_en = 0;
        drive_req(1'b1, 8'h03, 2'd0, 2'd0, 2'd0, 4'd0, $urandom);
        wait_accept();
        wait_resp(lat);
        frames.delete();
        check_data(1);
        release_resp(0);
        zero_wait = 0;
        no_rx = 0;
        junk_en = 1;
`endif

        for (int t = 0; t < 40; t++) begin
            stall_req = ($urandom_range(0, 4) == 0);
            rand_req();
            wait_accept();
            wait_resp(lat);
            check_data(0);
            release_resp(int'($urandom_range(0, 3)));
        end
        stall_req = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end
endmodule
